// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: pipeline hazard unit for the five-stage RISC-V core.
// It provides operand forwarding, the load-use stall and the branch/jump
// flush, plus a stall FSM for a multi-cycle execute unit (mul/div) and a
// saturating count of fetch-stall cycles.
//
// Multi-cycle handshake: the E-stage instruction raises MultiCycleE and
// keeps it high while it sits in E. McStart pulses in the first cycle it is
// accepted. McBusy follows the FSM state (BUSY), so it also serves as the
// state observation point. McDone marks the single cycle in which the result
// is valid; the instruction leaves E at the following edge.
module hazard_unit_mc #(
  parameter int REG_AW    = 5,
  parameter int MC_CYCLES = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic [1:0]        ResultSrcE,
  input  logic [1:0]        PCSrcE,
  input  logic              MultiCycleE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              McStart,
  output logic              McBusy,
  output logic              McDone,
  output logic [CNT_W-1:0]  StallCount
);

  // The down-counter spans MC_CYCLES-1 BUSY-side cycles; IDLE covers the first.
  localparam int CW = $clog2(MC_CYCLES);
  localparam logic [CW-1:0] CNT_INIT = CW'(MC_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_t;

  mc_state_t         state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              lw_stall;
  logic              mc_stall;
  logic              redir;

  // RegWriteE is not needed: a load in E always writes, and the other
  // hazards are resolved by forwarding from M/W.
  logic unused_ok;
  assign unused_ok = RegWriteE;

  // Operand forwarding: the M-stage ALU result has priority over W.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != '0) && (RdM == Rs1E))      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) ForwardAE = 2'b01;
    if (RegWriteM && (RdM != '0) && (RdM == Rs2E))      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) ForwardBE = 2'b01;
  end

  assign lw_stall = (ResultSrcE == 2'b01) && (RdE != '0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));
  assign redir    = (PCSrcE != 2'b00);

  // Multi-cycle FSM state and down-counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; a redirect in IDLE squashes the start.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    McStart   = 1'b0;
    McDone    = 1'b0;
    mc_stall  = 1'b0;
    case (state)
      IDLE: begin
        if (MultiCycleE && !redir) begin
          McStart   = 1'b1;
          mc_stall  = 1'b1;
          state_nxt = BUSY;
          cnt_nxt   = CNT_INIT;
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          mc_stall = 1'b1;
          cnt_nxt  = cnt - 1'b1;
        end else begin
          McDone    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign McBusy = (state == BUSY);

  // Stall/flush combination. E is held (never flushed) while the
  // multi-cycle unit works; a bubble goes into M instead.
  always_comb begin
    StallF = lw_stall || mc_stall;
    StallD = lw_stall || mc_stall;
    StallE = mc_stall;
    FlushD = redir;
    FlushE = redir || (lw_stall && !mc_stall);
    FlushM = mc_stall;
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      StallCount <= '0;
    end else if (StallF && (StallCount != CNT_MAX)) begin
      StallCount <= StallCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: directed vectors with hand-written expected
// outputs pushed into a queue; a negedge monitor pops and compares.
// A second instance with CNT_W=4 shares the inputs to cover saturation.
module tb_hazard_unit_mc;

  localparam int W = 33;  // {flags[12:0], count16, count4}

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       reg_write_e, reg_write_m, reg_write_w;
  logic [1:0] result_src_e, pc_src_e;
  logic       multi_cycle_e;

  logic       stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;
  logic [1:0] fwd_a, fwd_b;
  logic       mc_start, mc_busy, mc_done;
  logic [15:0] stall_count;

  logic       s_stall_f, s_stall_d, s_stall_e, s_flush_d, s_flush_e, s_flush_m;
  logic [1:0] s_fwd_a, s_fwd_b;
  logic       s_mc_start, s_mc_busy, s_mc_done;
  logic [3:0] s_stall_count;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           mdl_cnt16 = 0;
  int           mdl_cnt4 = 0;

  hazard_unit_mc #(.REG_AW(5), .MC_CYCLES(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .Rs1D(rs1_d), .Rs2D(rs2_d), .Rs1E(rs1_e), .Rs2E(rs2_e), .RdE(rd_e),
    .RdM(rd_m), .RdW(rd_w),
    .RegWriteE(reg_write_e), .RegWriteM(reg_write_m), .RegWriteW(reg_write_w),
    .ResultSrcE(result_src_e), .PCSrcE(pc_src_e), .MultiCycleE(multi_cycle_e),
    .StallF(stall_f), .StallD(stall_d), .StallE(stall_e),
    .FlushD(flush_d), .FlushE(flush_e), .FlushM(flush_m),
    .ForwardAE(fwd_a), .ForwardBE(fwd_b),
    .McStart(mc_start), .McBusy(mc_busy), .McDone(mc_done),
    .StallCount(stall_count)
  );

  hazard_unit_mc #(.REG_AW(5), .MC_CYCLES(4), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst),
    .Rs1D(rs1_d), .Rs2D(rs2_d), .Rs1E(rs1_e), .Rs2E(rs2_e), .RdE(rd_e),
    .RdM(rd_m), .RdW(rd_w),
    .RegWriteE(reg_write_e), .RegWriteM(reg_write_m), .RegWriteW(reg_write_w),
    .ResultSrcE(result_src_e), .PCSrcE(pc_src_e), .MultiCycleE(multi_cycle_e),
    .StallF(s_stall_f), .StallD(s_stall_d), .StallE(s_stall_e),
    .FlushD(s_flush_d), .FlushE(s_flush_e), .FlushM(s_flush_m),
    .ForwardAE(s_fwd_a), .ForwardBE(s_fwd_b),
    .McStart(s_mc_start), .McBusy(s_mc_busy), .McDone(s_mc_done),
    .StallCount(s_stall_count)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Drive all inputs to the quiet (no hazard) value.
  task automatic clear_inputs();
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
    reg_write_e = 1'b0; reg_write_m = 1'b0; reg_write_w = 1'b0;
    result_src_e = 2'b00; pc_src_e = 2'b00; multi_cycle_e = 1'b0;
  endtask

  // Inputs for this cycle are already applied; queue the expected outputs,
  // advance the stall-count model, then move to just after the next edge.
  task automatic step(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                      input logic sf, input logic se, input logic fd, input logic fe,
                      input logic fm, input logic mst, input logic mb, input logic md);
    logic [12:0] flags;
    flags = {sf, sf, se, fd, fe, fm, fa, fb, mst, mb, md};
    exp_q.push_back({flags, 16'(mdl_cnt16), 4'(mdl_cnt4)});
    name_q.push_back(nm);
    if (rst) begin
      mdl_cnt16 = 0;
      mdl_cnt4  = 0;
    end else if (sf) begin
      if (mdl_cnt16 < 65535) mdl_cnt16++;
      if (mdl_cnt4 < 15)     mdl_cnt4++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    mdl_cnt16 = 0;
    mdl_cnt4  = 0;
  endtask

  // Monitor: compare every queued expectation at the negedge of its cycle.
  always @(negedge clk) begin
    logic [W-1:0] e, a;
    string        n;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, fwd_a, fwd_b,
           mc_start, mc_busy, mc_done, stall_count, s_stall_count};
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL %s: got %h required %h", n, a, e);
      end
      n_cmp++;
      if ({s_stall_f, s_stall_d, s_stall_e, s_flush_d, s_flush_e, s_flush_m, s_fwd_a,
           s_fwd_b, s_mc_start, s_mc_busy, s_mc_done} !== e[32:20]) begin
        n_err++;
        $display("FAIL %s_cnt4inst: got flags %h required %h", n,
                 {s_stall_f, s_stall_d, s_stall_e, s_flush_d, s_flush_e, s_flush_m,
                  s_fwd_a, s_fwd_b, s_mc_start, s_mc_busy, s_mc_done}, e[32:20]);
      end
    end
  end

  // Directed stimulus.
  initial begin
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    //                 name          fa     fb     sf se fd fe fm st bz dn
    step("reset_idle", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);

    // Forwarding
    rd_m = 5; rd_w = 5; rs1_e = 5; reg_write_m = 1; reg_write_w = 1;
    step("fwd_a_m",    2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    reg_write_m = 0;
    step("fwd_a_w",    2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    rs1_e = 0; rd_m = 0; rd_w = 0; reg_write_m = 1;
    step("fwd_x0",     2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    rs1_e = 3; rs2_e = 9; rd_m = 9; rd_w = 9;
    step("fwd_b_m",    2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0);
    rd_m = 4;
    step("fwd_b_w",    2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0);

    // Load-use
    clear_inputs();
    result_src_e = 2'b01; rd_e = 7; rs2_d = 7;
    step("lw_stall",   2'b00, 2'b00, 1, 0, 0, 1, 0, 0, 0, 0);
    result_src_e = 2'b00;
    step("lw_after",   2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    result_src_e = 2'b01; rd_e = 0; rs1_d = 0; rs2_d = 0;
    step("lw_rd0",     2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);

    // Redirect wins over a multi-cycle start in IDLE
    clear_inputs();
    pc_src_e = 2'b01; multi_cycle_e = 1;
    step("redir_mc",   2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0);
    clear_inputs();
    step("redir_post", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);

    // Multi-cycle, back to back, with a coincident load-use in the second
    do_reset();
    multi_cycle_e = 1;
    step("mc0_c0",     2'b00, 2'b00, 1, 1, 0, 0, 1, 1, 0, 0);
    step("mc0_c1",     2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 1, 0);
    step("mc0_c2",     2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 1, 0);
    step("mc0_c3",     2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1);
    step("mc1_c4",     2'b00, 2'b00, 1, 1, 0, 0, 1, 1, 0, 0);
    result_src_e = 2'b01; rd_e = 7; rs1_d = 7;
    step("mc1_lw",     2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 1, 0);
    clear_inputs();
    multi_cycle_e = 1;
    step("mc1_c6",     2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 1, 0);
    step("mc1_c7",     2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1);
    multi_cycle_e = 0;
    step("mc_idle",    2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a BUSY sequence
    multi_cycle_e = 1;
    step("rst_c0",     2'b00, 2'b00, 1, 1, 0, 0, 1, 1, 0, 0);
    rst = 1'b1;
    step("rst_c1",     2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 1, 0);
    rst = 1'b0;
    multi_cycle_e = 0;
    step("rst_after",  2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rst_nodone", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);

    // Saturation: 20 load-use stall cycles, then one quiet cycle
    do_reset();
    result_src_e = 2'b01; rd_e = 7; rs2_d = 7;
    for (int i = 0; i < 20; i++) begin
      step("sat_hold", 2'b00, 2'b00, 1, 0, 0, 1, 0, 0, 0, 0);
    end
    clear_inputs();
    step("sat_end",    2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL queue_drain: got %0d left required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mc.md
# hazard_unit_mc

Parametrised hazard unit for the five-stage pipelined RISC-V core. It keeps the existing forwarding, load-use stall and branch/jump flush behaviour. It adds a stall state machine for a multi-cycle execute unit (mul/div) with a configurable latency, and a saturating stall-cycle performance counter. It sits between the datapath pipeline registers and the controller, in the same position as the single-cycle hazard unit.

## Interface
- `REG_AW`, default 5: register-address width.
- `MC_CYCLES`, default 4: total cycles a multi-cycle instruction occupies E; must be ≥2.
- `CNT_W`, default 16: stall-counter width.

Ports:
- `clk`  in  1  rising-edge clock (single clock domain).
- `rst`  in  1  synchronous, active-high reset.
- `Rs1D`, `Rs2D`  in  REG_AW  source registers of the instruction in D.
- `Rs1E`, `Rs2E`, `RdE`  in  REG_AW  source and destination registers of the instruction in E.
- `RdM`, `RdW`  in  REG_AW  destination registers in M and W.
- `RegWriteE`, `RegWriteM`, `RegWriteW`  in  1  register-write enables per stage.
- `ResultSrcE`  in  2  result select in E; 2'b01 marks a load.
- `PCSrcE`  in  2  non-zero marks a taken branch, jal or jalr redirect.
- `MultiCycleE`  in  1  instruction in E uses the multi-cycle unit.
- `StallF`, `StallD`, `StallE`  out  1  hold the PC, IF/ID and ID/EX registers.
- `FlushD`, `FlushE`, `FlushM`  out  1  bubble the IF/ID, ID/EX and EX/MEM registers.
- `ForwardAE`, `ForwardBE`  out  2  ALU operand select: 00 register file, 01 W result, 10 M ALU result.
- `McStart`, `McBusy`, `McDone`  out  1  multi-cycle unit start pulse, busy indication and result-valid indication.
- `StallCount`  out  CNT_W  saturating count of cycles with `StallF` high.

## Operation
Forwarding (combinational):
- `ForwardAE` = 10 if `RegWriteM` and `RdM`≠0 and `RdM`==`Rs1E`.
- Otherwise 01 if `RegWriteW` and `RdW`≠0 and `RdW`==`Rs1E`.
- Otherwise 00.
- M takes priority over W.
- `ForwardBE` is computed the same way using `Rs2E`.

Load-use stall:
- lwStall = (`ResultSrcE`==01) and `RdE`≠0 and (`RdE`==`Rs1D` or `RdE`==`Rs2D`).

Redirect:
- redir = (`PCSrcE`≠0).

Multi-cycle FSM: state IDLE/BUSY, with a down-counter `cnt` of width $clog2(MC_CYCLES).
- IDLE: if `MultiCycleE` and not redir, assert `McStart`, go to BUSY, `cnt`←MC_CYCLES−2.
- BUSY, `cnt`≠0: `cnt`←`cnt`−1.
- BUSY, `cnt`==0: assert `McDone` and go to IDLE. The instruction leaves E at the next edge.
- `McBusy` = (state==BUSY).
- mcStall = (IDLE and `MultiCycleE` and not redir) or (BUSY and `cnt`≠0).

Outputs:
- `StallF` = `StallD` = lwStall or mcStall.
- `StallE` = mcStall.
- `FlushD` = redir.
- `FlushE` = redir or (lwStall and not mcStall). The E register is held during mcStall, never flushed.
- `FlushM` = mcStall, so a bubble enters M while E is held.

`StallCount`:
- Increments by 1 on each edge where `StallF`=1.
- Holds at 2^CNT_W−1 (saturates, no wrap).

## Timing
- Reset: at an edge with `rst`=1, state←IDLE, `cnt`←0, `StallCount`←0. This applies mid-operation as well and aborts a BUSY sequence without asserting `McDone`. After reset, `McBusy`=0, `McDone`=0, and all other outputs are functions of the inputs with FSM in IDLE.
- Forward, stall and flush outputs are combinational, so they are valid in the same cycle as their inputs.
- Multi-cycle latency: let cycle 0 be the first cycle the instruction is in E.
  - Cycles 0..MC_CYCLES−2: mcStall=1, which is MC_CYCLES−1 stall cycles.
  - Cycle MC_CYCLES−1: `McDone`=1 and stall=0.
- Back-to-back multi-cycle instructions: the FSM returns to IDLE after `McDone`, and the next instruction starts on the following cycle with no idle gap.
- A load in E and a dependent instruction in D while the FSM is BUSY is not possible by construction. If lwStall and mcStall coincide, the stall outputs are the OR of both and `FlushE`=0.
- `MultiCycleE` together with redir in IDLE: redir wins and no start occurs.

## Test plan
- Forwarding: RdM=RdW=Rs1E=5, RegWriteM=RegWriteW=1 → ForwardAE=10. With RegWriteM=0 → 01. With Rs1E=0 and RdM=RdW=0 → 00.
- Load-use: ResultSrcE=01, RdE=7, Rs2D=7 → StallF=StallD=FlushE=1, StallE=0 for exactly one cycle. With RdE=0 → no stall.
- Redirect: PCSrcE=01 → FlushD=FlushE=1, StallF=0. Same cycle with MultiCycleE=1 in IDLE → McStart=0, McBusy stays 0.
- Multi-cycle, MC_CYCLES=4, MultiCycleE=1 from cycle 0:
  - McStart=1 at cycle 0.
  - StallF/D/E and FlushM high on cycles 0–2.
  - McDone=1 and stalls low on cycle 3.
  - StallCount=3.
  - A second multi-cycle op on cycle 4 → McStart=1 on cycle 4.
- Reset mid-operation: assert rst on cycle 1 of a busy sequence → next cycle McBusy=0, StallCount=0, and McDone is never asserted for the aborted op.
- Saturation: CNT_W=4, hold a load-use stall for 20 cycles → StallCount reaches 15 and stays at 15.
